// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: host-side command sequencer and scancode buffer for one
// PS/2 device. Sends single-byte commands, waits for the 0xFA acknowledge,
// retries on resend/failure/timeout and queues unsolicited bytes in a FIFO.
module ps2_host_ctrl #(
   parameter int FIFO_DEPTH  = 8,
   parameter int ACK_TIMEOUT = 500000,
   parameter int TX_TIMEOUT  = 65535,
   parameter int MAX_RETRY   = 3
) (
   input  logic       iClk,
   input  logic       iRstN,
   input  logic       iEnable,
   input  logic       iCmdValid,
   input  logic [7:0] iCmdData,
   output logic       oCmdReady,
   output logic       oCmdDone,
   output logic [1:0] oCmdStatus,
   output logic       oKeyValid,
   output logic [7:0] oKeyData,
   input  logic       iKeyReady,
   output logic       oOverrun,
   output logic       oTx,
   output logic [7:0] oTxData,
   input  logic       iTxOk,
   input  logic       iTxFail,
   output logic       oInhibit,
   input  logic       iRx,
   input  logic [7:0] iRxData
);

   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;
   localparam int TMAX   = (ACK_TIMEOUT > TX_TIMEOUT) ? ACK_TIMEOUT : TX_TIMEOUT;
   localparam int TW_RAW = $clog2(TMAX + 1);
   localparam int TW     = (TW_RAW < 20) ? 20 : TW_RAW;
   localparam int RW_RAW = $clog2(MAX_RETRY + 1);
   localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

   localparam logic [7:0]    ACK_BYTE    = 8'hFA;
   localparam logic [7:0]    RESEND_BYTE = 8'hFE;
   localparam logic [TW-1:0] ACK_LOAD    = TW'(ACK_TIMEOUT);
   localparam logic [TW-1:0] TX_LOAD     = TW'(TX_TIMEOUT);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] INH_LEVEL   = CW'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_TX_WAIT, S_ACK_WAIT, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [RW-1:0]  retry_q, retry_d;
   logic [1:0]     status_q, status_d;
   logic [7:0]     tx_data_q;
   logic           armed_q;
   logic           alive_q;
   logic           accept;
   logic           fail;
   logic [1:0]     fail_code;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [7:0]     key_data_q;
   logic           full, pop, push, rx_to_fifo, fifo_hi;

   // FIFO status and receive-path routing; ack/resend bytes are swallowed only while awaiting a reply
   always_comb begin
      full       = (count_q == DEPTH_C);
      fifo_hi    = (count_q >= INH_LEVEL);
      oKeyValid  = (count_q != '0);
      pop        = oKeyValid & iKeyReady;
      rx_to_fifo = iRx & ~((state_q == S_ACK_WAIT) &
                           ((iRxData == ACK_BYTE) | (iRxData == RESEND_BYTE)));
      push       = rx_to_fifo & (~full | pop);
      oOverrun   = rx_to_fifo & full & ~pop;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Command sequencer: next state, timer/retry bookkeeping and handshake outputs
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      status_d  = status_q;
      fail      = 1'b0;
      fail_code = 2'd0;
      oCmdReady = 1'b0;
      oInhibit  = 1'b0;
      oTx       = 1'b0;
      oCmdDone  = 1'b0;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // alive_q keeps the port quiet and the device inhibited until the first edge after reset
            oCmdReady = alive_q & iEnable;
            oInhibit  = ~alive_q | ~iEnable | fifo_hi;
            accept    = iCmdValid & oCmdReady;
            if (accept) begin
               retry_d = '0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            // one full cycle of released inhibit before the transmit pulse
            if (armed_q) begin
               oTx     = 1'b1;
               timer_d = TX_LOAD;
               state_d = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            if (iTxOk) begin
               timer_d = ACK_LOAD;
               state_d = S_ACK_WAIT;
            end else if (iTxFail || (timer_q == '0)) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_ACK_WAIT: begin
            if (iRx && (iRxData == ACK_BYTE)) begin
               status_d = 2'd0;
               state_d  = S_DONE;
            end else if (iRx && (iRxData == RESEND_BYTE)) begin
               fail      = 1'b1;
               fail_code = 2'd1;
            end else if (timer_q == '0) begin
               fail      = 1'b1;
               fail_code = 2'd2;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_DONE: begin
            oCmdDone = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (fail) begin
         if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ARM;
         end else begin
            status_d = fail_code;
            state_d  = S_DONE;
         end
      end
   end

   assign oCmdStatus = status_q;
   assign oTxData    = tx_data_q;
   assign oKeyData   = key_data_q;

   // Sequencer state register and command byte latch
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         retry_q   <= '0;
         status_q  <= 2'd0;
         tx_data_q <= 8'h00;
         armed_q   <= 1'b0;
         alive_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         retry_q  <= retry_d;
         status_q <= status_d;
         armed_q  <= (state_q == S_ARM) & ~oTx;
         alive_q  <= 1'b1;
         if (accept) tx_data_q <= iCmdData;
      end
   end

   // Scancode storage; empty slots carry no meaning so no reset is needed
   always_ff @(posedge iClk) begin
      if (push) mem[wr_ptr_q] <= iRxData;
   end

   // FIFO pointers, occupancy and registered head byte
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         key_data_q <= 8'h00;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         // a byte written into the slot that becomes the head must bypass the memory read
         if (push && (rd_ptr_d == wr_ptr_q)) key_data_q <= iRxData;
         else if (pop && (count_d != '0))    key_data_q <= mem[rd_ptr_d];
      end
   end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed scenarios for the PS/2 host sequencer with a
// scripted device responder and hand-computed expectations.
module tb_ps2_host_ctrl;

   logic       clk;
   logic       iRstN;
   logic       iEnable;
   logic       iCmdValid;
   logic [7:0] iCmdData;
   logic       oCmdReady;
   logic       oCmdDone;
   logic [1:0] oCmdStatus;
   logic       oKeyValid;
   logic [7:0] oKeyData;
   logic       iKeyReady;
   logic       oOverrun;
   logic       oTx;
   logic [7:0] oTxData;
   logic       iTxOk;
   logic       iTxFail;
   logic       oInhibit;
   logic       iRx;
   logic [7:0] iRxData;

   int checks;
   int errors;

   localparam logic [23:0] RST_VEC = {1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};

   ps2_host_ctrl #(
      .FIFO_DEPTH (4),
      .ACK_TIMEOUT(100),
      .TX_TIMEOUT (60),
      .MAX_RETRY  (3)
   ) dut (
      .iClk      (clk),
      .iRstN     (iRstN),
      .iEnable   (iEnable),
      .iCmdValid (iCmdValid),
      .iCmdData  (iCmdData),
      .oCmdReady (oCmdReady),
      .oCmdDone  (oCmdDone),
      .oCmdStatus(oCmdStatus),
      .oKeyValid (oKeyValid),
      .oKeyData  (oKeyData),
      .iKeyReady (iKeyReady),
      .oOverrun  (oOverrun),
      .oTx       (oTx),
      .oTxData   (oTxData),
      .iTxOk     (iTxOk),
      .iTxFail   (iTxFail),
      .oInhibit  (oInhibit),
      .iRx       (iRx),
      .iRxData   (iRxData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Device modes: 0 ok+FA, 1 ok+FE always, 2 ok then silence, 3 txfail always,
   // 4 ok+1C+FA, 5 never answers the transmit
   task automatic run_cmd(input logic [7:0] cmd, input int mode, input int budget,
                          output bit done, output logic [1:0] st, output int txc,
                          output logic [7:0] txd, output int gap);
      int ph;
      int last_c;
      done = 1'b0; st = 2'd0; txc = 0; txd = 8'h00; gap = 0; ph = 0; last_c = 0;
      @(negedge clk);
      iCmdValid = 1'b1;
      iCmdData  = cmd;
      #1;
      checks++;
      if (oCmdReady !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready: got %b expected 1", oCmdReady);
      end
      @(negedge clk);
      iCmdValid = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         iTxOk = 1'b0; iTxFail = 1'b0; iRx = 1'b0;
         if (oCmdDone) begin
            done = 1'b1;
            st   = oCmdStatus;
         end else if (oTx) begin
            if (txc == 1) gap = c - last_c;
            txc++;
            txd    = oTxData;
            last_c = c;
            ph     = 1;
         end else begin
            case (ph)
               1: begin
                  if (mode == 3) begin iTxFail = 1'b1; ph = 0; end
                  else if (mode == 5) ph = 0;
                  else begin iTxOk = 1'b1; ph = (mode == 2) ? 0 : 2; end
               end
               2: begin
                  iRx = 1'b1;
                  if (mode == 1)      begin iRxData = 8'hFE; ph = 0; end
                  else if (mode == 4) begin iRxData = 8'h1C; ph = 3; end
                  else                begin iRxData = 8'hFA; ph = 0; end
               end
               3: begin iRx = 1'b1; iRxData = 8'hFA; ph = 0; end
               default: ph = 0;
            endcase
         end
      end
      iTxOk = 1'b0; iTxFail = 1'b0; iRx = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL cmd_timeout: got no oCmdDone within %0d cycles, required a completion", budget);
      end
   endtask

   task automatic push_byte(input logic [7:0] d, output logic ovr);
      @(negedge clk);
      iRx = 1'b1;
      iRxData = d;
      #1 ovr = oOverrun;
      @(negedge clk);
      iRx = 1'b0;
   endtask

   task automatic test_reset;
      iRstN = 1'b0; iEnable = 1'b1; iCmdValid = 1'b0; iCmdData = 8'h00;
      iKeyReady = 1'b0; iTxOk = 1'b0; iTxFail = 1'b0; iRx = 1'b0; iRxData = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({oCmdReady, oCmdDone, oCmdStatus, oKeyValid, oKeyData, oOverrun, oTx, oTxData, oInhibit} !== RST_VEC) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h",
                  {oCmdReady, oCmdDone, oCmdStatus, oKeyValid, oKeyData, oOverrun, oTx, oTxData, oInhibit}, RST_VEC);
      end
      iRstN = 1'b1;
      #1;
      checks++;
      if (oCmdReady !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b expected 0", oCmdReady);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({oCmdReady, oInhibit} !== 2'b10) begin
         errors++;
         $display("FAIL ready_after_reset: got ready/inhibit %b expected 10", {oCmdReady, oInhibit});
      end
   endtask

   task automatic test_enable;
      bit tx_seen;
      tx_seen = 1'b0;
      @(negedge clk);
      iEnable = 1'b0;
      iCmdValid = 1'b1;
      iCmdData = 8'hAA;
      #1;
      checks++;
      if ({oCmdReady, oInhibit} !== 2'b01) begin
         errors++;
         $display("FAIL disabled_handshake: got ready/inhibit %b expected 01", {oCmdReady, oInhibit});
      end
      repeat (4) begin
         @(negedge clk);
         if (oTx) tx_seen = 1'b1;
      end
      iCmdValid = 1'b0;
      iEnable = 1'b1;
      checks++;
      if (tx_seen !== 1'b0) begin
         errors++;
         $display("FAIL disabled_no_tx: got oTx %b expected 0", tx_seen);
      end
   endtask

   task automatic test_basic;
      bit dn; logic [1:0] st; int txc; logic [7:0] txd; int gap;
      run_cmd(8'hED, 0, 50, dn, st, txc, txd, gap);
      checks++;
      if ({txc[7:0], txd, st} !== {8'd1, 8'hED, 2'd0}) begin
         errors++;
         $display("FAIL basic_cmd: got tx_count %0d data %h status %0d expected 1 ED 0", txc, txd, st);
      end
      #1;
      checks++;
      if (oKeyValid !== 1'b0) begin
         errors++;
         $display("FAIL basic_fifo_untouched: got oKeyValid %b expected 0", oKeyValid);
      end
   endtask

   task automatic test_resend;
      bit dn; logic [1:0] st; int txc; logic [7:0] txd; int gap;
      run_cmd(8'hF4, 1, 100, dn, st, txc, txd, gap);
      checks++;
      if ({txc[7:0], txd, st} !== {8'd4, 8'hF4, 2'd1}) begin
         errors++;
         $display("FAIL resend_exhaust: got tx_count %0d data %h status %0d expected 4 F4 1", txc, txd, st);
      end
   endtask

   task automatic test_ack_timeout;
      bit dn; logic [1:0] st; int txc; logic [7:0] txd; int gap;
      run_cmd(8'hF2, 2, 700, dn, st, txc, txd, gap);
      checks++;
      if ({txc[7:0], st} !== {8'd4, 2'd2}) begin
         errors++;
         $display("FAIL ack_timeout: got tx_count %0d status %0d expected 4 2", txc, st);
      end
      checks++;
      if (gap < 100 || gap > 110) begin
         errors++;
         $display("FAIL ack_timeout_gap: got %0d cycles between pulses, required 100..110", gap);
      end
   endtask

   task automatic test_tx_fail;
      bit dn; logic [1:0] st; int txc; logic [7:0] txd; int gap;
      run_cmd(8'hEE, 3, 100, dn, st, txc, txd, gap);
      checks++;
      if ({txc[7:0], st} !== {8'd4, 2'd3}) begin
         errors++;
         $display("FAIL tx_fail: got tx_count %0d status %0d expected 4 3", txc, st);
      end
      run_cmd(8'hEE, 5, 500, dn, st, txc, txd, gap);
      checks++;
      if ({txc[7:0], st} !== {8'd4, 2'd3}) begin
         errors++;
         $display("FAIL tx_timeout: got tx_count %0d status %0d expected 4 3", txc, st);
      end
   endtask

   task automatic test_interleaved;
      bit dn; logic [1:0] st; int txc; logic [7:0] txd; int gap;
      run_cmd(8'hF3, 4, 50, dn, st, txc, txd, gap);
      #1;
      checks++;
      if ({st, oKeyValid, oKeyData} !== {2'd0, 1'b1, 8'h1C}) begin
         errors++;
         $display("FAIL interleaved: got status %0d valid %b data %h expected 0 1 1C", st, oKeyValid, oKeyData);
      end
      @(negedge clk);
      iKeyReady = 1'b1;
      @(negedge clk);
      iKeyReady = 1'b0;
      #1;
      checks++;
      if (oKeyValid !== 1'b0) begin
         errors++;
         $display("FAIL interleaved_only_one: got oKeyValid %b expected 0", oKeyValid);
      end
   endtask

   task automatic test_fifo;
      logic ovr;
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
      push_byte(8'h11, ovr);
      push_byte(8'h22, ovr);
      #1;
      checks++;
      if (oInhibit !== 1'b0) begin
         errors++;
         $display("FAIL inhibit_two_free: got %b expected 0", oInhibit);
      end
      push_byte(8'h33, ovr);
      #1;
      checks++;
      if ({oInhibit, oKeyValid, oKeyData} !== {1'b1, 1'b1, 8'h11}) begin
         errors++;
         $display("FAIL inhibit_one_free: got inhibit %b valid %b head %h expected 1 1 11", oInhibit, oKeyValid, oKeyData);
      end
      push_byte(8'h44, ovr);
      checks++;
      if (ovr !== 1'b0) begin
         errors++;
         $display("FAIL fill_no_overrun: got %b expected 0", ovr);
      end
      push_byte(8'h55, ovr);
      checks++;
      if (ovr !== 1'b1) begin
         errors++;
         $display("FAIL overrun_on_full: got %b expected 1", ovr);
      end
      @(negedge clk);
      iRx = 1'b1; iRxData = 8'h66; iKeyReady = 1'b1;
      #1;
      checks++;
      if (oOverrun !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop_overrun: got %b expected 0", oOverrun);
      end
      @(negedge clk);
      iRx = 1'b0; iKeyReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         iKeyReady = 1'b0;
         #1;
         checks++;
         if ({oKeyValid, oKeyData} !== {1'b1, exp_q[i]}) begin
            errors++;
            $display("FAIL pop_order_%0d: got valid %b data %h expected 1 %h", i, oKeyValid, oKeyData, exp_q[i]);
         end
         iKeyReady = 1'b1;
      end
      @(negedge clk);
      iKeyReady = 1'b0;
      #1;
      checks++;
      if ({oKeyValid, oInhibit} !== 2'b00) begin
         errors++;
         $display("FAIL fifo_drained: got valid/inhibit %b expected 00", {oKeyValid, oInhibit});
      end
   endtask

   task automatic test_reset_mid;
      logic ovr;
      bit dn;
      push_byte(8'h77, ovr);
      @(negedge clk);
      iCmdValid = 1'b1; iCmdData = 8'hF2;
      @(negedge clk);
      iCmdValid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({oTx, oTxData} !== {1'b1, 8'hF2}) begin
         errors++;
         $display("FAIL arm_latency: got tx %b data %h expected 1 F2", oTx, oTxData);
      end
      @(negedge clk);
      #2 iRstN = 1'b0;
      #1;
      checks++;
      if ({oCmdReady, oCmdDone, oCmdStatus, oKeyValid, oKeyData, oOverrun, oTx, oTxData, oInhibit} !== RST_VEC) begin
         errors++;
         $display("FAIL midreset_outputs: got %h expected %h",
                  {oCmdReady, oCmdDone, oCmdStatus, oKeyValid, oKeyData, oOverrun, oTx, oTxData, oInhibit}, RST_VEC);
      end
      dn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (oCmdDone) dn = 1'b1;
      end
      #2 iRstN = 1'b1;
      #1;
      checks++;
      if ({dn, oCmdReady} !== 2'b00) begin
         errors++;
         $display("FAIL midreset_no_done: got done/ready %b expected 00", {dn, oCmdReady});
      end
      @(negedge clk);
      #1;
      checks++;
      if (oCmdReady !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: got %b expected 1", oCmdReady);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_enable();
      test_basic();
      test_resend();
      test_ack_timeout();
      test_tx_fail();
      test_interleaved();
      test_fifo();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
